// File: rtl/mem_port_arbiter.sv
// Two-master arbiter serializing core (m0) and PIM/loader (m1) word requests onto one RAM controller port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build gives fixed core priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wmask,
    input  logic                m0_rstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rbusy,
    output logic                m0_wbusy,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    input  logic                m1_rstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rbusy,
    output logic                m1_wbusy,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    output logic                s_rstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rbusy,
    input  logic                s_wbusy
);
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [1:0]        slot_valid;
    logic [1:0]        slot_write;
    logic [ADDR_W-1:0] slot_addr  [2];
    logic [DATA_W-1:0] slot_wdata [2];
    logic [MASK_W-1:0] slot_wmask [2];
    logic              grant;
    logic              winner;

    logic [ADDR_W-1:0] in_addr  [2];
    logic [DATA_W-1:0] in_wdata [2];
    logic [MASK_W-1:0] in_wmask [2];
    logic [1:0]        req_wr;
    logic [1:0]        req_rd;

    assign in_addr[0]  = m0_addr;
    assign in_addr[1]  = m1_addr;
    assign in_wdata[0] = m0_wdata;
    assign in_wdata[1] = m1_wdata;
    assign in_wmask[0] = m0_wmask;
    assign in_wmask[1] = m1_wmask;

    // A write strobe wins over a simultaneous read strobe; the read is dropped.
    assign req_wr = {|m1_wmask, |m0_wmask};
    assign req_rd = {m1_rstrb & ~req_wr[1], m0_rstrb & ~req_wr[0]};

    assign m0_rbusy = req_rd[0] | (slot_valid[0] & ~slot_write[0]);
    assign m0_wbusy = req_wr[0] | (slot_valid[0] &  slot_write[0]);
    assign m1_rbusy = req_rd[1] | (slot_valid[1] & ~slot_write[1]);
    assign m1_wbusy = req_wr[1] | (slot_valid[1] &  slot_write[1]);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    assign winner = (slot_valid == 2'b11) ? ~last_grant : ~slot_valid[0];
`else
    assign winner = ~slot_valid[0];
`endif

    // Slave port: strobe only in the IDLE grant cycle, address/data held through WAIT.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wmask = '0;
        s_rstrb = 1'b0;
        if (state == WAIT) begin
            s_addr  = slot_addr[grant];
            s_wdata = slot_wdata[grant];
        end else if (|slot_valid) begin
            s_addr  = slot_addr[winner];
            s_wdata = slot_wdata[winner];
            s_rstrb = ~slot_write[winner];
            s_wmask = slot_write[winner] ? slot_wmask[winner] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            slot_valid <= '0;
            slot_write <= '0;
            grant      <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
            for (int i = 0; i < 2; i++) begin
                slot_addr[i]  <= '0;
                slot_wdata[i] <= '0;
                slot_wmask[i] <= '0;
            end
        end else begin
            // Strobes against an occupied slot are ignored.
            for (int i = 0; i < 2; i++) begin
                if (!slot_valid[i] && (req_wr[i] || req_rd[i])) begin
                    slot_valid[i] <= 1'b1;
                    slot_write[i] <= req_wr[i];
                    slot_addr[i]  <= in_addr[i];
                    slot_wdata[i] <= in_wdata[i];
                    slot_wmask[i] <= in_wmask[i];
                end
            end
            case (state)
                IDLE: begin
                    if (|slot_valid) begin
                        grant <= winner;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!s_rbusy && !s_wbusy) begin
                        slot_valid[grant] <= 1'b0;
                        if (!slot_write[grant]) begin
                            if (grant) m1_rdata <= s_rdata;
                            else       m0_rdata <= s_rdata;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= grant;
`endif
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed timing steps, then randomized traffic
// checked against a transaction-level model (controller data is a pure function of address).
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_rstrb, m1_rstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;
    logic        s_rstrb, s_rbusy, s_wbusy;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
        .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
        .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
        .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
    endfunction

    // Controller model: busy for lat cycles after each access, read data = rd_fn(addr).
    int          lat_cfg  = 0;
    int          busy_cnt = 0;
    logic        busy_rd  = 1'b0;
    logic [31:0] rd_q     = '0;
    int          acc_cnt  = 0;
    logic [31:0] wr_sum   = '0;
    int          viol     = 0;
    logic        prev_acc = 1'b0;
    logic        acc;

    assign acc     = s_rstrb | (s_wmask != 4'd0);
    assign s_rbusy = (busy_cnt != 0) && busy_rd;
    assign s_wbusy = (busy_cnt != 0) && !busy_rd;
    assign s_rdata = rd_q;

    always @(posedge clk) begin
        if (acc) begin
            busy_cnt <= (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
            busy_rd  <= s_rstrb;
            rd_q     <= rd_fn(s_addr);
            acc_cnt  <= acc_cnt + 1;
            if (s_wmask != 4'd0) wr_sum <= wr_sum + (s_addr ^ s_wdata ^ {28'd0, s_wmask});
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Protocol monitor: no back-to-back slave accesses, never read and write together.
    always @(negedge clk) begin
        if ((acc && prev_acc) || (s_rstrb && s_wmask != 4'd0)) viol <= viol + 1;
        prev_acc <= acc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        m0_rstrb = 1'b0; m0_wmask = 4'd0;
        m1_rstrb = 1'b0; m1_wmask = 4'd0;
    endtask

    task automatic drive(input int m, input logic rd, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] data);
        if (m == 0) begin
            m0_rstrb = rd; m0_wmask = mask; m0_addr = addr; m0_wdata = data;
        end else begin
            m1_rstrb = rd; m1_wmask = mask; m1_addr = addr; m1_wdata = data;
        end
    endtask

    logic        pend [2];
    logic        pwr  [2];
    logic [31:0] paddr[2];
    int          age  [2];

    initial begin
        int          acc0;
        int          issued;
        logic [31:0] wr0;
        logic [31:0] exp_wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  mk;
        logic        busy;

        reset = 1'b1;
        m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
        clear_inputs();
        cyc(); cyc();
        // Reset state; busy follows strobes even in reset.
        m1_wmask = 4'h1; settle();
        check("rst_m1_wbusy_strobe", 32'(m1_wbusy), 32'd1);
        check("rst_m0_rbusy", 32'(m0_rbusy), 32'd0);
        check("rst_s_rstrb", 32'(s_rstrb), 32'd0);
        check("rst_s_wmask", 32'(s_wmask), 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        clear_inputs();
        cyc();
        reset = 1'b0; settle();
        check("rst_m1_wbusy_after", 32'(m1_wbusy), 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);

        // Simultaneous reads after reset: core wins first in both modes.
        cyc();
        drive(0, 1'b1, 4'd0, 32'h20, 32'd0);
        drive(1, 1'b1, 4'd0, 32'h24, 32'd0); settle();
        check("pair_t0_m0_rbusy", 32'(m0_rbusy), 32'd1);
        check("pair_t0_m1_rbusy", 32'(m1_rbusy), 32'd1);
        check("pair_t0_s_rstrb", 32'(s_rstrb), 32'd0);
        cyc(); clear_inputs(); settle();
        check("pair_t1_s_rstrb", 32'(s_rstrb), 32'd1);
        check("pair_t1_s_addr", s_addr, 32'h20);
        cyc(); settle();
        check("pair_t2_s_rstrb", 32'(s_rstrb), 32'd0);
        check("pair_t2_m0_rbusy", 32'(m0_rbusy), 32'd1);
        cyc(); settle();
        check("pair_t3_m0_rbusy", 32'(m0_rbusy), 32'd0);
        check("pair_t3_m0_rdata", m0_rdata, rd_fn(32'h20));
        check("pair_t3_s_rstrb", 32'(s_rstrb), 32'd1);
        check("pair_t3_s_addr", s_addr, 32'h24);
        cyc(); settle();
        check("pair_t4_s_rstrb", 32'(s_rstrb), 32'd0);
        check("pair_t4_m1_rbusy", 32'(m1_rbusy), 32'd1);
        cyc(); settle();
        check("pair_t5_m1_rbusy", 32'(m1_rbusy), 32'd0);
        check("pair_t5_m1_rdata", m1_rdata, rd_fn(32'h24));

        // Uncontended core read; a re-strobe in the completion cycle is ignored.
        cyc(); acc0 = acc_cnt;
        drive(0, 1'b1, 4'd0, 32'h10, 32'd0); settle();
        check("rd_t0_m0_rbusy", 32'(m0_rbusy), 32'd1);
        cyc(); clear_inputs(); settle();
        check("rd_t1_s_rstrb", 32'(s_rstrb), 32'd1);
        check("rd_t1_s_addr", s_addr, 32'h10);
        cyc(); drive(0, 1'b1, 4'd0, 32'h99, 32'd0); settle();
        check("rd_t2_m0_rbusy", 32'(m0_rbusy), 32'd1);
        cyc(); clear_inputs(); settle();
        check("rd_t3_m0_rbusy", 32'(m0_rbusy), 32'd0);
        check("rd_t3_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd_t3_m1_rdata", m1_rdata, rd_fn(32'h24));
        check("rd_t3_m1_rbusy", 32'(m1_rbusy), 32'd0);
        cyc(); cyc(); settle();
        check("rd_restrobe_dropped", 32'(acc_cnt - acc0), 32'd1);

        // Second simultaneous pair after a core grant.
        cyc();
        drive(0, 1'b1, 4'd0, 32'h30, 32'd0);
        drive(1, 1'b1, 4'd0, 32'h34, 32'd0);
        cyc(); clear_inputs(); settle();
`ifdef ARB_ROUND_ROBIN_EN
        check("pair2_first_addr", s_addr, 32'h34);
`else
        check("pair2_first_addr", s_addr, 32'h30);
`endif
        cyc(); cyc(); settle();
`ifdef ARB_ROUND_ROBIN_EN
        check("pair2_second_addr", s_addr, 32'h30);
`else
        check("pair2_second_addr", s_addr, 32'h34);
`endif
        cyc(); cyc(); settle();
        check("pair2_m0_rdata", m0_rdata, rd_fn(32'h30));
        check("pair2_m1_rdata", m1_rdata, rd_fn(32'h34));

        // m1 write while m0 read pending.
        cyc(); wr0 = wr_sum;
        drive(0, 1'b1, 4'd0, 32'h50, 32'd0);
        cyc(); clear_inputs();
        drive(1, 1'b0, 4'h3, 32'h60, 32'h0000A5A5); settle();
        check("wr_t1_s_rstrb", 32'(s_rstrb), 32'd1);
        check("wr_t1_s_wmask", 32'(s_wmask), 32'd0);
        check("wr_t1_m1_wbusy", 32'(m1_wbusy), 32'd1);
        cyc(); clear_inputs(); settle();
        check("wr_t2_s_wmask", 32'(s_wmask), 32'd0);
        cyc(); settle();
        check("wr_t3_s_wmask", 32'(s_wmask), 32'h3);
        check("wr_t3_s_addr", s_addr, 32'h60);
        check("wr_t3_s_wdata", s_wdata, 32'h0000A5A5);
        check("wr_t3_m0_rdata", m0_rdata, rd_fn(32'h50));
        cyc(); settle();
        check("wr_t4_s_wmask", 32'(s_wmask), 32'd0);
        check("wr_t4_m1_wbusy", 32'(m1_wbusy), 32'd1);
        cyc(); settle();
        check("wr_t5_m1_wbusy", 32'(m1_wbusy), 32'd0);
        check("wr_sum", wr_sum - wr0, 32'h60 ^ 32'h0000A5A5 ^ 32'h3);

        // Controller stretches busy for 4 cycles.
        lat_cfg = 4;
        cyc(); drive(0, 1'b1, 4'd0, 32'h40, 32'd0);
        cyc(); clear_inputs(); settle();
        check("str_t1_s_rstrb", 32'(s_rstrb), 32'd1);
        for (int i = 2; i <= 6; i++) begin
            cyc(); settle();
            check($sformatf("str_t%0d_m0_rbusy", i), 32'(m0_rbusy), 32'd1);
            check($sformatf("str_t%0d_s_rstrb", i), 32'(s_rstrb), 32'd0);
        end
        cyc(); settle();
        check("str_t7_m0_rbusy", 32'(m0_rbusy), 32'd0);
        check("str_t7_m0_rdata", m0_rdata, rd_fn(32'h40));

        // Duplicate strobes while slot valid issue exactly one slave read.
        lat_cfg = 2;
        cyc(); acc0 = acc_cnt;
        drive(0, 1'b1, 4'd0, 32'h70, 32'd0);
        cyc(); drive(0, 1'b1, 4'd0, 32'h74, 32'd0);
        cyc(); drive(0, 1'b1, 4'd0, 32'h78, 32'd0);
        cyc(); clear_inputs();
        cyc(); settle();
        check("dup_t4_m0_rbusy", 32'(m0_rbusy), 32'd1);
        cyc(); settle();
        check("dup_t5_m0_rbusy", 32'(m0_rbusy), 32'd0);
        check("dup_m0_rdata", m0_rdata, rd_fn(32'h70));
        check("dup_slave_reads", 32'(acc_cnt - acc0), 32'd1);

        // Reset during WAIT with both slots valid.
        lat_cfg = 4;
        cyc();
        drive(0, 1'b1, 4'd0, 32'h80, 32'd0);
        drive(1, 1'b1, 4'd0, 32'h84, 32'd0);
        cyc(); clear_inputs();
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; settle(); acc0 = acc_cnt;
        check("rstw_m0_rbusy", 32'(m0_rbusy), 32'd0);
        check("rstw_m1_rbusy", 32'(m1_rbusy), 32'd0);
        check("rstw_m0_rdata", m0_rdata, 32'd0);
        check("rstw_m1_rdata", m1_rdata, 32'd0);
        check("rstw_s_rstrb", 32'(s_rstrb), 32'd0);
        repeat (6) cyc();
        check("rstw_no_access", 32'(acc_cnt - acc0), 32'd0);

        // Randomized traffic with random controller latency.
        lat_cfg = -1;
        acc0 = acc_cnt; wr0 = wr_sum; exp_wr = '0; issued = 0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; pwr[m] = 1'b0; paddr[m] = '0; age[m] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            cyc(); clear_inputs(); settle();
            for (int m = 0; m < 2; m++) begin
                busy = (m == 0) ? (m0_rbusy | m0_wbusy) : (m1_rbusy | m1_wbusy);
                if (pend[m]) begin
                    age[m]++;
                    if (!busy) begin
                        if (!pwr[m])
                            check($sformatf("rnd_m%0d_rdata", m),
                                  (m == 0) ? m0_rdata : m1_rdata, rd_fn(paddr[m]));
                        pend[m] = 1'b0;
                    end else if (age[m] > 60) begin
                        check($sformatf("rnd_m%0d_timeout_busy", m), 32'(busy), 32'd0);
                        pend[m] = 1'b0;
                    end
                end
                if (!pend[m] && c < 550 && $urandom_range(0, 2) != 0) begin
                    a  = {20'd0, 10'($urandom), 2'b00};
                    d  = $urandom;
                    mk = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
                    drive(m, mk == 4'd0, mk, a, d);
                    pend[m] = 1'b1; pwr[m] = (mk != 4'd0); paddr[m] = a; age[m] = 0;
                    issued++;
                    if (mk != 4'd0) exp_wr = exp_wr + (a ^ d ^ {28'd0, mk});
                end
            end
        end
        check("rnd_drained_m0", 32'(pend[0]), 32'd0);
        check("rnd_drained_m1", 32'(pend[1]), 32'd0);
        check("rnd_access_count", 32'(acc_cnt - acc0), 32'(issued));
        check("rnd_write_sum", wr_sum - wr0, exp_wr);
        check("protocol_violations", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter placed directly upstream of the RAM controller: it accepts word requests from the RISC-V core (master 0) and from the PIM engine / program loader (master 1) and serializes them onto the controller's single core-side port. Each master sees the same strobe/busy protocol it would see when wired straight to the controller. Per-master request capture lets a master pulse its strobe for one cycle even while the other master owns the port.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; byte mask width is DATA_W/8
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mN_addr  in  ADDR_W  master N request address (N = 0 core, 1 PIM)
- mN_wdata  in  DATA_W  master N write data
- mN_wmask  in  DATA_W/8  master N byte write mask; nonzero = write strobe
- mN_rstrb  in  1  master N read strobe, one-cycle pulse
- mN_rdata  out  DATA_W  master N read data, registered
- mN_rbusy  out  1  master N read outstanding
- mN_wbusy  out  1  master N write outstanding
- s_addr  out  ADDR_W  to controller address
- s_wdata  out  DATA_W  to controller write data
- s_wmask  out  DATA_W/8  to controller byte mask
- s_rstrb  out  1  to controller read strobe
- s_rdata  in  DATA_W  from controller read data
- s_rbusy  in  1  controller read busy
- s_wbusy  in  1  controller write busy

## Operation
- Per master one pending slot: valid, is_write, addr, wdata, wmask. Loaded at clock edge when master strobes and slot is empty.
- Strobe with slot already valid: ignored, slot unchanged (protocol violation).
- wmask nonzero and rstrb both high in one cycle: captured as write; read dropped, rbusy not raised.
- mN_rbusy = mN_rstrb | (slot valid & !is_write); mN_wbusy = (|mN_wmask) | (slot valid & is_write). Combinational, so busy is high in the strobe cycle itself.
- FSM states IDLE, WAIT.
  - IDLE: if any slot valid, select winner, drive s_* from its slot (s_rstrb = !is_write, s_wmask = is_write ? wmask : 0) for exactly this cycle; record grant; go WAIT. Otherwise s_rstrb = 0, s_wmask = 0.
  - WAIT: s_rstrb = 0, s_wmask = 0, s_addr/s_wdata hold the granted slot. When s_rbusy = 0 and s_wbusy = 0: read → mN_rdata <= s_rdata; clear granted slot; update last-grant; go IDLE. Else stay.
- mN_rdata holds last captured value until next read completion for that master.
- Selection per Configuration. Only the granted slot is cleared at completion; the other stays valid.

## Timing
- Reset: state IDLE, both slots invalid, mN_rdata = 0, last-grant = master 1 (so master 0 wins first tie), all s_* outputs 0, busy outputs follow strobes only.
- Reset mid-transaction: pending slots discarded, no completion reported; the in-flight controller access is abandoned.
- Uncontended read: strobe T0, slave strobe T1, capture end T2; rbusy low and rdata valid T3 (3 cycles). Write identical; wbusy low T3.
- Slot freed in completion cycle; a new strobe in that same cycle is ignored (slot still valid at that edge). Earliest accepted re-strobe is the cycle rbusy/wbusy reads low.
- Back-to-back grants: completion T, next slave strobe T+1. No slave strobe is ever issued in consecutive cycles.
- Controller stretching busy past one cycle extends WAIT cycle-for-cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both slots valid in IDLE, grant the master not granted last; single valid slot always wins.
- Not defined: fixed priority, master 0 (core) always wins a tie; master 1 can starve while the core streams requests. Last-grant register is omitted.

## Test plan
- Core read addr 0x10, controller returns 0xDEADBEEF after 1 cycle -> s_rstrb at T1 with s_addr 0x10, m0_rbusy high T0–T2, m0_rdata = 0xDEADBEEF at T3, m1 outputs unchanged.
- Both masters read same cycle (m0 0x20, m1 0x24) -> m0 granted first at T1, m1 slave strobe at T3, m1_rdata valid T5; with ARB_ROUND_ROBIN_EN, a second simultaneous pair grants m1 first.
- m1 write wmask 0x3 data 0x0000A5A5 while m0 read pending -> s_wmask = 0x3 only on its grant cycle, s_wmask 0 at all other cycles, m1_wbusy low two cycles after grant.
- Controller holds s_rbusy high 4 cycles after strobe -> FSM stays WAIT, m0_rbusy high throughout, capture on first cycle both busy low.
- Reset asserted in WAIT with both slots valid -> next cycle state IDLE, slots invalid, m0_rdata = m1_rdata = 0, no further slave strobe.
- Duplicate m0_rstrb while slot valid -> ignored; exactly one slave read issued.
